// File: rtl/monitor_log_pkg.sv
// -----------------------------------------------------------------------------
// monitor_log_pkg
// Shared types and constants for the RTLola monitor output logger.
//   - LOG_NUM_OUT / LOG_DATA_W / LOG_TS_W / LOG_DEPTH : default geometry.
//     The snapshot and record structs are sized from these constants.
//   - ID_W       : width of a stream index.
//   - DROP_CNT_W : width of the saturating drop counter.
//   - snapshot_t : one captured cycle {ts, active mask, all stream values}.
//   - record_t   : one serialised output record {ts, id, value}.
//   - lowest_idx : index of the lowest set bit of an active mask.
// -----------------------------------------------------------------------------
package monitor_log_pkg;

    localparam int LOG_NUM_OUT = 3;
    localparam int LOG_DATA_W  = 64;
    localparam int LOG_TS_W    = 32;
    localparam int LOG_DEPTH   = 8;

    localparam int ID_W       = (LOG_NUM_OUT > 1) ? $clog2(LOG_NUM_OUT) : 1;
    localparam int DROP_CNT_W = 16;

    typedef struct packed {
        logic [LOG_TS_W-1:0]                      ts;
        logic [LOG_NUM_OUT-1:0]                   mask;
        logic [LOG_NUM_OUT-1:0][LOG_DATA_W-1:0]   values;
    } snapshot_t;

    typedef struct packed {
        logic [LOG_TS_W-1:0]   ts;
        logic [ID_W-1:0]       id;
        logic [LOG_DATA_W-1:0] value;
    } record_t;

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_EMIT = 1'b1
    } ser_state_t;

    // Returns the index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [ID_W-1:0] lowest_idx(input logic [LOG_NUM_OUT-1:0] mask);
        logic [ID_W-1:0] idx;
        idx = '0;
        for (int i = LOG_NUM_OUT - 1; i >= 0; i--) begin
            if (mask[i]) begin
                idx = ID_W'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/log_snapshot_fifo.sv
// -----------------------------------------------------------------------------
// log_snapshot_fifo
// Synchronous FIFO of DEPTH snapshots (DEPTH a power of two).
// Ports:
//   clk, rst       : clock, asynchronous active-low reset
//   push, push_data: write one entry (caller only pushes when !full or popping)
//   pop            : drop the head entry (caller only pops when !empty)
//   head           : current head entry (combinational read)
//   next_head      : entry behind the head, valid when multi is high
//   empty, full    : occupancy flags
//   multi          : at least two entries held
// A push and pop in the same cycle on a full FIFO both succeed: the write
// lands in the slot being vacated, and the count is unchanged.
// -----------------------------------------------------------------------------
module log_snapshot_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] push_data,
    input  logic         pop,
    output logic [W-1:0] head,
    output logic [W-1:0] next_head,
    output logic         empty,
    output logic         full,
    output logic         multi
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;

    assign empty     = (count == '0);
    assign full      = (count == (AW+1)'(DEPTH));
    assign multi     = (count > (AW+1)'(1));
    assign head      = mem[rd_ptr];
    assign next_head = mem[rd_ptr + AW'(1)];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/monitor_output_logger.sv
// -----------------------------------------------------------------------------
// monitor_output_logger
// Captures every enabled cycle with at least one active monitor output,
// timestamps it, buffers it and serialises it as one record per active stream.
// Ports:
//   clk, rst          : clock, asynchronous active-low reset
//   en                : gates timestamp counting and capture
//   out_value         : stream i at [i*DATA_W +: DATA_W]
//   out_aktv          : per-stream active flags
//   rec_valid/ready   : record handshake
//   rec_ts/id/value   : registered record fields
//   overflow          : sticky, set when a snapshot is dropped
//   drop_count        : saturating count of dropped snapshots
//   dbg_state         : serializer FSM state (0 idle, 1 emit)
// Handshake: a record transfers on a rising edge where rec_valid and
// rec_ready are both high; rec_valid and the record fields hold until then.
// Widths follow monitor_log_pkg; parameters must match the package values.
// -----------------------------------------------------------------------------
module monitor_output_logger
    import monitor_log_pkg::*;
#(
    parameter int NUM_OUT = LOG_NUM_OUT,
    parameter int DATA_W  = LOG_DATA_W,
    parameter int TS_W    = LOG_TS_W,
    parameter int DEPTH   = LOG_DEPTH
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     en,
    input  logic [NUM_OUT*DATA_W-1:0] out_value,
    input  logic [NUM_OUT-1:0]       out_aktv,
    output logic                     rec_valid,
    input  logic                     rec_ready,
    output logic [TS_W-1:0]          rec_ts,
    output logic [ID_W-1:0]          rec_id,
    output logic [DATA_W-1:0]        rec_value,
    output logic                     overflow,
    output logic [DROP_CNT_W-1:0]    drop_count,
    output logic                     dbg_state
);

    logic [TS_W-1:0] ts;

    snapshot_t cap_snap;
    snapshot_t head;
    snapshot_t next_head;
    logic      fifo_empty;
    logic      fifo_full;
    logic      fifo_multi;
    logic      capture;
    logic      push;
    logic      pop;
    logic      drop;

    ser_state_t           state, state_n;
    logic [NUM_OUT-1:0]   mask, mask_n;
    logic [NUM_OUT-1:0]   rem;
    logic                 valid_n;
    record_t              rec_q, rec_n;

    // ---------------------------------------------------------------- capture
    assign capture = en && (|out_aktv);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts.
    assign push    = capture && (!fifo_full || pop);
    assign drop    = capture && fifo_full && !pop;

    assign cap_snap.ts     = ts;
    assign cap_snap.mask   = out_aktv;
    assign cap_snap.values = out_value;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ts <= '0;
        end else if (en) begin
            ts <= ts + TS_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow   <= 1'b0;
            drop_count <= '0;
        end else if (drop) begin
            overflow <= 1'b1;
            if (drop_count != '1) begin
                drop_count <= drop_count + DROP_CNT_W'(1);
            end
        end
    end

    log_snapshot_fifo #(
        .W     ($bits(snapshot_t)),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (cap_snap),
        .pop       (pop),
        .head      (head),
        .next_head (next_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .multi     (fifo_multi)
    );

    // ------------------------------------------------------------- serializer
    // The head snapshot stays in the FIFO while its records are emitted; the
    // working mask tracks which streams remain.
    assign rem = mask & ~(NUM_OUT'(1) << rec_q.id);

    always_comb begin
        state_n = state;
        mask_n  = mask;
        valid_n = rec_valid;
        rec_n   = rec_q;
        pop     = 1'b0;

        case (state)
            S_IDLE: begin
                if (!fifo_empty) begin
                    state_n     = S_EMIT;
                    mask_n      = head.mask;
                    valid_n     = 1'b1;
                    rec_n.ts    = head.ts;
                    rec_n.id    = lowest_idx(head.mask);
                    rec_n.value = head.values[lowest_idx(head.mask)];
                end
            end
            S_EMIT: begin
                if (rec_valid && rec_ready) begin
                    if (rem != '0) begin
                        mask_n      = rem;
                        rec_n.id    = lowest_idx(rem);
                        rec_n.value = head.values[lowest_idx(rem)];
                    end else begin
                        pop = 1'b1;
                        // Chain straight into the next snapshot when one is
                        // already buffered behind the head.
                        if (fifo_multi) begin
                            mask_n      = next_head.mask;
                            rec_n.ts    = next_head.ts;
                            rec_n.id    = lowest_idx(next_head.mask);
                            rec_n.value = next_head.values[lowest_idx(next_head.mask)];
                        end else begin
                            state_n = S_IDLE;
                            mask_n  = '0;
                            valid_n = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_n = S_IDLE;
                mask_n  = '0;
                valid_n = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= S_IDLE;
            mask      <= '0;
            rec_valid <= 1'b0;
            rec_q     <= '0;
        end else begin
            state     <= state_n;
            mask      <= mask_n;
            rec_valid <= valid_n;
            rec_q     <= rec_n;
        end
    end

    assign rec_ts    = rec_q.ts;
    assign rec_id    = rec_q.id;
    assign rec_value = rec_q.value;
    assign dbg_state = state;

endmodule

// File: tb/tb_monitor_output_logger.sv
module tb_monitor_output_logger;

  localparam int NUM_OUT = 3;
  localparam int DATA_W  = 64;
  localparam int TS_W    = 32;
  localparam int DEPTH   = 8;

  logic                      clk;
  logic                      rst;
  logic                      en;
  logic [NUM_OUT*DATA_W-1:0] out_value;
  logic [NUM_OUT-1:0]        out_aktv;
  logic                      rec_valid;
  logic                      rec_ready;
  logic [TS_W-1:0]           rec_ts;
  logic [1:0]                rec_id;
  logic [DATA_W-1:0]         rec_value;
  logic                      overflow;
  logic [15:0]               drop_count;
  logic                      dbg_state;

  int n_tests;
  int n_fail;
  int tb_ts;
  logic [TS_W-1:0] exp_q[$];
  logic [TS_W-1:0] exp_ts;
  logic [TS_W-1:0] frozen_ts;

  monitor_output_logger #(
    .NUM_OUT (NUM_OUT),
    .DATA_W  (DATA_W),
    .TS_W    (TS_W),
    .DEPTH   (DEPTH)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .en         (en),
    .out_value  (out_value),
    .out_aktv   (out_aktv),
    .rec_valid  (rec_valid),
    .rec_ready  (rec_ready),
    .rec_ts     (rec_ts),
    .rec_id     (rec_id),
    .rec_value  (rec_value),
    .overflow   (overflow),
    .drop_count (drop_count),
    .dbg_state  (dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout: simulation time limit reached");
    $fatal(1, "timeout");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One clock edge; inputs set before the call are sampled at that edge,
  // outputs are observed 1 ns after it.
  task automatic step();
    if (en && rst) tb_ts++;
    @(posedge clk);
    #1;
  endtask

  task automatic set_vals(input logic [63:0] v0, input logic [63:0] v1, input logic [63:0] v2);
    out_value = {v2, v1, v0};
  endtask

  task automatic check_rec(input string tag, input logic [31:0] ts, input logic [1:0] id, input logic [63:0] val);
    check({tag, "_valid"}, 64'(rec_valid), 64'd1);
    check({tag, "_ts"}, 64'(rec_ts), 64'(ts));
    check({tag, "_id"}, 64'(rec_id), 64'(id));
    check({tag, "_value"}, rec_value, val);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, 64'(rec_valid), 64'd0);
    check({tag, "_ts"}, 64'(rec_ts), 64'd0);
    check({tag, "_id"}, 64'(rec_id), 64'd0);
    check({tag, "_value"}, rec_value, 64'd0);
    check({tag, "_overflow"}, 64'(overflow), 64'd0);
    check({tag, "_drop"}, 64'(drop_count), 64'd0);
    check({tag, "_state"}, 64'(dbg_state), 64'd0);
  endtask

  initial begin
    n_tests   = 0;
    n_fail    = 0;
    tb_ts     = 0;
    rst       = 1'b0;
    en        = 1'b0;
    out_aktv  = '0;
    out_value = '0;
    rec_ready = 1'b1;
    step();
    step();
    check_zero("reset");
    rst = 1'b1;

    // single stream at ts=10
    en = 1'b1;
    while (tb_ts < 10) step();
    out_aktv = 3'b001;
    set_vals(64'd5, 64'd0, 64'd0);
    step();
    out_aktv = '0;
    check("single_lat_valid", 64'(rec_valid), 64'd0);
    step();
    check_rec("single", 32'd10, 2'd0, 64'd5);
    step();
    check("single_done", 64'(rec_valid), 64'd0);

    // multi stream at ts=20
    while (tb_ts < 20) step();
    out_aktv = 3'b111;
    set_vals(64'd1, 64'd2, 64'd3);
    step();
    out_aktv = '0;
    step();
    check_rec("multi0", 32'd20, 2'd0, 64'd1);
    step();
    check_rec("multi1", 32'd20, 2'd1, 64'd2);
    step();
    check_rec("multi2", 32'd20, 2'd2, 64'd3);
    step();
    check("multi_done", 64'(rec_valid), 64'd0);

    // backpressure
    rec_ready = 1'b0;
    exp_ts = TS_W'(tb_ts);
    out_aktv = 3'b101;
    set_vals(64'd7, 64'd0, -64'sd4);
    step();
    out_aktv = '0;
    step();
    for (int i = 0; i < 5; i++) begin
      check_rec($sformatf("bp_hold%0d", i), exp_ts, 2'd0, 64'd7);
      if (i < 4) step();
    end
    rec_ready = 1'b1;
    step();
    check_rec("bp_second", exp_ts, 2'd2, 64'hFFFF_FFFF_FFFF_FFFC);
    step();
    check("bp_done", 64'(rec_valid), 64'd0);

    // overflow: 10 captures into an 8-deep FIFO with the consumer stalled
    rec_ready = 1'b0;
    out_aktv  = 3'b001;
    for (int i = 0; i < 10; i++) begin
      set_vals(64'(i), 64'd0, 64'd0);
      if (i < DEPTH) exp_q.push_back(TS_W'(tb_ts));
      step();
    end
    out_aktv = '0;
    check("ovf_flag", 64'(overflow), 64'd1);
    check("ovf_drop", 64'(drop_count), 64'd2);
    rec_ready = 1'b1;
    for (int j = 0; j < DEPTH; j++) begin
      exp_ts = exp_q.pop_front();
      check_rec($sformatf("ovf_drain%0d", j), exp_ts, 2'd0, 64'(j));
      step();
    end
    check("ovf_done", 64'(rec_valid), 64'd0);
    check("ovf_sticky", 64'(overflow), 64'd1);

    // en gating
    en = 1'b0;
    frozen_ts = TS_W'(tb_ts);
    out_aktv = 3'b010;
    set_vals(64'd0, 64'd99, 64'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("en_off%0d", i), 64'(rec_valid), 64'd0);
    end
    en = 1'b1;
    step();
    out_aktv = '0;
    step();
    check_rec("en_resume", frozen_ts, 2'd1, 64'd99);
    step();
    check("en_done", 64'(rec_valid), 64'd0);

    // reset during the second record of a 3-record snapshot
    out_aktv = 3'b111;
    set_vals(64'd11, 64'd12, 64'd13);
    step();
    out_aktv = '0;
    step();
    step();
    check("rst_mid_id", 64'(rec_id), 64'd1);
    rst = 1'b0;
    #1;
    check_zero("rst_async");
    step();
    step();
    check_zero("rst_hold");
    rst   = 1'b1;
    tb_ts = 0;
    out_aktv = 3'b100;
    set_vals(64'd0, 64'd0, 64'd42);
    step();
    out_aktv = '0;
    step();
    check_rec("post_rst", 32'd0, 2'd2, 64'd42);
    for (int i = 0; i < 4; i++) begin
      step();
      check($sformatf("post_rst_idle%0d", i), 64'(rec_valid), 64'd0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
